// File: rtl/microwave_timer.sv
// Microwave cooking timer: keypad-entered 4-digit BCD MM:SS value that counts
// down once per second while the magnetron is on, flagging expiry.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse,
    output logic [1:0] state_dbg
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SET   = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_d, mo_d, st_d, so_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_pulse_q, done_pulse_d;

    logic          key_ok, count_en, tick, dec_zero;
    logic          b0, b1, b2;
    logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;

    // One-second BCD decrement; seconds tens borrows to 5 so entries like 1:90 count normally.
    always_comb begin
        b0     = (so_q == 4'd0);
        dec_so = b0 ? 4'd9 : so_q - 4'd1;
        dec_st = b0 ? ((st_q == 4'd0) ? 4'd5 : st_q - 4'd1) : st_q;
        b1     = b0 && (st_q == 4'd0);
        dec_mo = b1 ? ((mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1) : mo_q;
        b2     = b1 && (mo_q == 4'd0);
        dec_mt = b2 ? mt_q - 4'd1 : mt_q;
        dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'd0);
    end

    assign key_ok   = key_valid && (key_digit <= 4'd9) && !mag_on;
    assign count_en = mag_on && (state_q != ST_EMPTY);
    assign tick     = count_en && (pre_q == TICK_MAX);

    always_comb begin
        state_d      = state_q;
        mt_d         = mt_q;
        mo_d         = mo_q;
        st_d         = st_q;
        so_d         = so_q;
        pre_d        = pre_q;
        done_pulse_d = 1'b0;
        if (!clearn) begin
            state_d = ST_EMPTY;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            pre_d   = '0;
        end else if (key_ok) begin
            mt_d    = mo_q;
            mo_d    = st_q;
            st_d    = so_q;
            so_d    = key_digit;
            pre_d   = '0;
            // Shifting can push the only nonzero digit out of min_tens.
            state_d = ({mo_q, st_q, so_q, key_digit} != 16'd0) ? ST_SET : ST_EMPTY;
        end else begin
            case (state_q)
                ST_SET, ST_RUN: begin
                    if (count_en) begin
                        state_d = ST_RUN;
                        if (tick) begin
                            pre_d = '0;
                            mt_d  = dec_mt;
                            mo_d  = dec_mo;
                            st_d  = dec_st;
                            so_d  = dec_so;
                            if (dec_zero) begin
                                state_d      = ST_EMPTY;
                                done_pulse_d = 1'b1;
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end else begin
                        // Pause keeps the prescaler so sub-second progress survives.
                        state_d = ST_SET;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            mt_q         <= 4'd0;
            mo_q         <= 4'd0;
            st_q         <= 4'd0;
            so_q         <= 4'd0;
            pre_q        <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mt_q         <= mt_d;
            mo_q         <= mo_d;
            st_q         <= st_d;
            so_q         <= so_d;
            pre_q        <= pre_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign min_tens   = mt_q;
    assign min_ones   = mo_q;
    assign sec_tens   = st_q;
    assign sec_ones   = so_q;
    assign timer_done = ({mt_q, mo_q, st_q, so_q} == 16'd0);
    assign done_pulse = done_pulse_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cooking-time countdown stage directly upstream of the magnetron control logic; it produces the timer-done condition that logic consumes.
- Holds a 4-digit BCD MM:SS value entered digit-by-digit from the keypad.
- Counts down once per second while mag_on is high.
- Flags expiry with a level timer_done and a one-cycle done_pulse.

Parameters:
- TICKS_PER_SEC, 1000, clk cycles per second (1 kHz clock at 1 ms timescale); must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- clearn  input  1  active-low synchronous clear of time value and prescaler.
- key_valid  input  1  one-cycle strobe: key_digit is valid this cycle.
- key_digit  input  4  BCD digit 0-9; codes 10-15 are ignored.
- mag_on  input  1  magnetron-on feedback; high = count enabled.
- min_tens  output  4  BCD minutes tens.
- min_ones  output  4  BCD minutes ones.
- sec_tens  output  4  BCD seconds tens (0-9 accepted on entry).
- sec_ones  output  4  BCD seconds ones.
- timer_done  output  1  high while all four digits are zero.
- done_pulse  output  1  one-cycle pulse when a running countdown reaches 00:00.

Behaviour:
- Reset (rst=1, async):
  - all digits 0, prescaler 0, state EMPTY.
  - timer_done=1, done_pulse=0.
- Clock and reset are fixed: one clock; reset is asynchronous and active-high (clk, rst).
- All outputs are registered. timer_done is decoded from registered digits; it changes in the same cycle the digits change.
- Per-cycle priority, highest first:
  1. clearn=0
  2. key entry
  3. count tick
- clearn=0:
  - digits := 0, prescaler := 0, state EMPTY.
  - key_valid and tick in the same cycle are ignored.
- Key entry: accepted only when key_valid=1, key_digit<=9 and mag_on=0.
  - Left-shift: min_tens:=min_ones, min_ones:=sec_tens, sec_tens:=sec_ones, sec_ones:=key_digit.
  - Old min_tens is discarded.
  - prescaler := 0.
  - Keys while mag_on=1 are ignored, with no other effect.
- Prescaler: counts 0..TICKS_PER_SEC-1 only in state RUN.
  - It holds its value when mag_on drops, so pause/resume keeps sub-second progress.
  - A tick occurs in the cycle it equals TICKS_PER_SEC-1 and mag_on=1; it then wraps to 0.
- BCD decrement on tick:
  - sec_ones 0 -> 9 with a borrow; otherwise decrement.
  - sec_tens borrow: 0 -> 5 with a borrow to minutes; otherwise decrement. Entered values such as 1:90 therefore count 90, 89, ... normally.
  - min_ones 0 -> 9 with a borrow; min_tens decrements.
  - Never decrement from 00:00.
  - Maximum value 99:99.
- FSM states:
  - EMPTY: digits = 0.
    - Accepted key with nonzero digit -> SET.
    - Key 0 stays EMPTY.
    - mag_on is ignored.
  - SET: nonzero, not counting.
    - mag_on=1 -> RUN.
    - clearn -> EMPTY.
  - RUN: prescaler advancing.
    - mag_on=0 -> SET (pause).
    - Tick that yields 00:00 -> EMPTY, done_pulse=1 in that same registered cycle, prescaler := 0.
- done_pulse:
  - Never asserted by clearn or reset, only by expiry.
  - Width is exactly one cycle even if mag_on stays high.
- mag_on falling in the same cycle a tick would occur: no tick. The condition requires mag_on=1 in that cycle.
- rst asserted mid-count: immediate return to reset values. No done_pulse.

Test Plan:
- Reset / entry: assert rst, release -> timer_done=1, digits 00:00. Keys 1,3,0 with mag_on=0 -> 01:30 (min_ones=1, sec_tens=3, sec_ones=0), timer_done=0.
- Countdown (TICKS_PER_SEC=4): load 01:02, mag_on=1 -> 01:01 after 4 clks, 01:00 after 8, 00:59 after 12. Borrow path verified.
- Expiry: load 00:02, mag_on=1.
  - After 8 clks: 00:00, timer_done=1, done_pulse high exactly one cycle.
  - No further decrement with mag_on still 1.
- Pause/resume: load 00:05, run 6 clks (00:04, prescaler=2), mag_on=0 for 10 clks -> value/prescaler hold. Resume -> 00:03 after 2 more clks.
- Priority / ignore:
  - Key 7 while mag_on=1 -> ignored.
  - key_digit=12 -> ignored.
  - clearn=0 coincident with key_valid and tick -> 00:00, no done_pulse.
- Overflow shift: keys 1,2,3,4,5 -> 23:45. Async rst mid-RUN -> immediate 00:00, done_pulse=0.
